// File: rtl/booth_multiplier_seq_pkg.sv
// Shared types for the sequential radix-4 Booth multiplier: FSM states, Booth selections, default width.
package mul_pkg;

  localparam int MUL_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    ZERO     = 3'd0,
    PLUS_M   = 3'd1,
    PLUS_2M  = 3'd2,
    MINUS_M  = 3'd3,
    MINUS_2M = 3'd4
  } booth_sel_e;

endpackage

// File: rtl/booth_multiplier_seq_if.sv
// Start/done handshake and operand/product bus of the Booth multiplier.
// MUL_OVF_FLAG_EN adds the registered ovf output.
interface booth_multiplier_seq_if
  import mul_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH
) ();

  logic                 start;
  logic [WIDTH-1:0]     multiplicand;
  logic [WIDTH-1:0]     multiplier;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   z;
`ifdef MUL_OVF_FLAG_EN
  logic                 ovf;

  modport master (output start, multiplicand, multiplier, input busy, done, z, ovf);
  modport slave  (input start, multiplicand, multiplier, output busy, done, z, ovf);
`else
  modport master (output start, multiplicand, multiplier, input busy, done, z);
  modport slave  (input start, multiplicand, multiplier, output busy, done, z);
`endif

endinterface

// File: rtl/booth_recoder.sv
// Radix-4 Booth recoder: maps {q1,q0,q-1} to a selection and forms the WIDTH+2-bit addend from M.
module booth_recoder
  import mul_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH
) (
  input  logic [2:0]       grp,
  input  logic [WIDTH+1:0] m,
  output logic [WIDTH+1:0] addend
);

  booth_sel_e       sel;
  logic [WIDTH+1:0] m2;

  assign m2 = {m[WIDTH:0], 1'b0};

  always_comb begin
    sel = ZERO;
    case (grp)
      3'b001, 3'b010: sel = PLUS_M;
      3'b011:         sel = PLUS_2M;
      3'b100:         sel = MINUS_2M;
      3'b101, 3'b110: sel = MINUS_M;
      default:        sel = ZERO;
    endcase
  end

  always_comb begin
    addend = '0;
    case (sel)
      PLUS_M:   addend = m;
      PLUS_2M:  addend = m2;
      MINUS_M:  addend = '0 - m;
      MINUS_2M: addend = '0 - m2;
      default:  addend = '0;
    endcase
  end

endmodule

// File: rtl/booth_multiplier_seq.sv
// Sequential signed radix-4 Booth multiplier, one partial product per clock, {HI,LO} on z.
// Optional ovf flag under MUL_OVF_FLAG_EN.
module booth_multiplier_seq
  import mul_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH
) (
  input  logic                   clock,
  input  logic                   clear_n,
  booth_multiplier_seq_if.slave  bus
);

  localparam int AW    = WIDTH + 2;
  localparam int STEPS = WIDTH / 2;
  localparam int CW    = $clog2(STEPS) + 1;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [AW-1:0]      a_q, a_d, m_q, m_d;
  logic [WIDTH:0]     q_q, q_d;       // {Q, q-1}
  logic [2*WIDTH-1:0] z_q, z_d;
  logic               busy_q, busy_d, done_q, done_d;
  logic [AW-1:0]      addend, sum;
  logic               load;

  booth_recoder #(.WIDTH(WIDTH)) u_rec (
    .grp    (q_q[2:0]),
    .m      (m_q),
    .addend (addend)
  );

  assign sum = a_q + addend;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    q_d     = q_q;
    m_d     = m_q;
    z_d     = z_q;
    load    = 1'b0;
    case (state_q)
      IDLE: load = bus.start;
      RUN: begin
        // add, then arithmetic shift {A,Q,q-1} right by two
        a_d   = {{2{sum[AW-1]}}, sum[AW-1:2]};
        q_d   = {sum[1:0], q_q[WIDTH:2]};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(STEPS - 1)) begin
          state_d = DONE;
          z_d     = {a_d[WIDTH-1:0], q_d[WIDTH:1]};
        end
      end
      DONE: begin
        load    = bus.start;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (load) begin
      state_d = RUN;
      cnt_d   = '0;
      a_d     = '0;
      q_d     = {bus.multiplier, 1'b0};
      m_d     = {{2{bus.multiplicand[WIDTH-1]}}, bus.multiplicand};
    end
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

`ifdef MUL_OVF_FLAG_EN
  logic ovf_q, ovf_d;
  // HI must be pure sign extension of LO for the product to fit in 32 bits
  assign ovf_d   = (z_d[2*WIDTH-1:WIDTH] != {WIDTH{z_d[WIDTH-1]}});
  assign bus.ovf = ovf_q;

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) ovf_q <= 1'b0;
    else          ovf_q <= ovf_d;
  end
`endif

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      q_q     <= '0;
      m_q     <= '0;
      z_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      q_q     <= q_d;
      m_q     <= m_d;
      z_q     <= z_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.z    = z_q;

endmodule

// File: tb/tb_booth_multiplier_seq.sv
// Directed self-checking bench for booth_multiplier_seq (ovf checks under MUL_OVF_FLAG_EN).
module tb_booth_multiplier_seq;

  logic clock;
  logic clear_n;
  int   n_vec;
  int   n_err;

  booth_multiplier_seq_if #(.WIDTH(32)) bus ();

  booth_multiplier_seq #(.WIDTH(32)) dut (
    .clock   (clock),
    .clear_n (clear_n),
    .bus     (bus)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present operands with start, take the accept edge, drop start.
  task automatic do_start(input logic [31:0] a, input logic [31:0] b);
    bus.start        = 1'b1;
    bus.multiplicand = a;
    bus.multiplier   = b;
    @(posedge clock);
    #1;
    bus.start = 1'b0;
  endtask

  // Count edges after accept until done is seen, and cycles with busy high.
  task automatic wait_done(output int edges, output int busy_cyc);
    edges    = 0;
    busy_cyc = bus.busy ? 1 : 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clock);
      #1;
      edges++;
      if (bus.done) break;
      if (bus.busy) busy_cyc++;
    end
  endtask

  int edges, bcyc, zbad;
  logic [63:0] zprev;

  initial begin
    n_vec = 0;
    n_err = 0;
    clear_n          = 1'b0;
    bus.start        = 1'b0;
    bus.multiplicand = '0;
    bus.multiplier   = '0;

    // reset state
    #12;
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_z",    bus.z,         64'd0);
`ifdef MUL_OVF_FLAG_EN
    chk("rst_ovf",  64'(bus.ovf),  64'd0);
`endif
    clear_n = 1'b1;
    @(negedge clock);

    // 6 x 7: latency and busy width
    do_start(32'd6, 32'd7);
    chk("t1_busy_e0", 64'(bus.busy), 64'd1);
    wait_done(edges, bcyc);
    chk("t1_edges", 64'(edges), 64'd16);
    chk("t1_busy_cyc", 64'(bcyc), 64'd16);
    chk("t1_busy_at_done", 64'(bus.busy), 64'd0);
    chk("t1_z", bus.z, 64'h0000_0000_0000_002A);
    @(posedge clock); #1;
    chk("t1_done_pulse", 64'(bus.done), 64'd0);
    chk("t1_z_hold", bus.z, 64'h0000_0000_0000_002A);

    // -5 x 3
    do_start(32'hFFFF_FFFB, 32'd3);
    wait_done(edges, bcyc);
    chk("t2_z", bus.z, 64'hFFFF_FFFF_FFFF_FFF1);
`ifdef MUL_OVF_FLAG_EN
    chk("t2_ovf", 64'(bus.ovf), 64'd0);
`endif

    // most-negative squared
    do_start(32'h8000_0000, 32'h8000_0000);
    wait_done(edges, bcyc);
    chk("t3_z", bus.z, 64'h4000_0000_0000_0000);
`ifdef MUL_OVF_FLAG_EN
    chk("t3_ovf", 64'(bus.ovf), 64'd1);
`endif

    // max-positive x -1, then back-to-back 2 x 3 from DONE
    do_start(32'h7FFF_FFFF, 32'hFFFF_FFFF);
    wait_done(edges, bcyc);
    chk("t4_z", bus.z, 64'hFFFF_FFFF_8000_0001);
`ifdef MUL_OVF_FLAG_EN
    chk("t4_ovf", 64'(bus.ovf), 64'd0);
`endif
    do_start(32'd2, 32'd3);
    chk("t4_b2b_busy", 64'(bus.busy), 64'd1);
    chk("t4_b2b_done", 64'(bus.done), 64'd0);
    wait_done(edges, bcyc);
    chk("t4_b2b_edges", 64'(edges), 64'd16);
    chk("t4_b2b_z", bus.z, 64'd6);

    // start held and operands scrambled during RUN
    @(posedge clock); #1;
    do_start(32'd100, 32'd200);
    bus.start = 1'b1;
    zprev = bus.z;
    zbad  = 0;
    edges = 0;
    for (int i = 0; i < 40; i++) begin
      bus.multiplicand = $urandom;
      bus.multiplier   = $urandom;
      @(posedge clock); #1;
      edges++;
      if (bus.done) break;
      if (bus.z !== zprev) zbad++;
    end
    bus.start = 1'b0;
    chk("t5_edges", 64'(edges), 64'd16);
    chk("t5_z_held", 64'(zbad), 64'd0);
    chk("t5_z", bus.z, 64'd20000);
    @(posedge clock); #1;
    chk("t5_idle_busy", 64'(bus.busy), 64'd0);
    chk("t5_idle_done", 64'(bus.done), 64'd0);

    // async clear mid-RUN
    do_start(32'd1234, 32'd5678);
    for (int i = 0; i < 8; i++) @(posedge clock);
    #2;
    clear_n = 1'b0;
    #1;
    chk("t6_clr_busy", 64'(bus.busy), 64'd0);
    chk("t6_clr_done", 64'(bus.done), 64'd0);
    chk("t6_clr_z",    bus.z,         64'd0);
`ifdef MUL_OVF_FLAG_EN
    chk("t6_clr_ovf",  64'(bus.ovf),  64'd0);
`endif
    @(negedge clock);
    clear_n = 1'b1;
    @(negedge clock);
    do_start(32'd2, 32'd3);
    wait_done(edges, bcyc);
    chk("t6_edges", 64'(edges), 64'd16);
    chk("t6_z", bus.z, 64'd6);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
